// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared pipeline widths, NOP constant and IF/ID entry type
package rv_pipe_pkg;
  localparam int XLEN  = 32;
  localparam int GHR_W = 4;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  predicted_pc;
    logic             prediction_valid;
    logic [GHR_W-1:0] ghr;
  } if_id_entry_t;
endpackage

// File: rtl/pipe_fifo_core.sv
// rtl/pipe_fifo_core.sv - generic DEPTH x WIDTH circular buffer with push, pop and flush
module pipe_fifo_core #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap on their own
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - fetch-to-decode instruction queue; IFID_LOAD_USE_EN adds load-use hazard detection
module if_id_queue #(
  parameter int XLEN  = rv_pipe_pkg::XLEN,
  parameter int GHR_W = rv_pipe_pkg::GHR_W,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_IF_in,
  output logic             ready_IF_out,
  input  logic [XLEN-1:0]  pc_IF_in,
  input  logic [XLEN-1:0]  instr_IF_in,
  input  logic [XLEN-1:0]  predicted_pc_IF_in,
  input  logic             prediction_valid_IF_in,
  input  logic [GHR_W-1:0] ghr_IF_in,
  input  logic             stall_ID_in,
  input  logic             flush_in,
  output logic             valid_ID_out,
  output logic [XLEN-1:0]  pc_ID_out,
  output logic [XLEN-1:0]  instr_ID_out,
  output logic [XLEN-1:0]  predicted_pc_ID_out,
  output logic             prediction_valid_ID_out,
  output logic [GHR_W-1:0] ghr_ID_out,
  output logic [CW-1:0]    count_out,
  output logic             bubble_ID_out
`ifdef IFID_LOAD_USE_EN
  ,
  input  logic [4:0]       rd_EX_in,
  input  logic             MemRead_EX_in
`endif
);
  import rv_pipe_pkg::*;

  localparam int WIDTH = 3 * XLEN + 1 + GHR_W;

  logic [WIDTH-1:0] wdata, rdata;
  logic             push, pop, full, empty, hazard, stall_eff;
  logic [XLEN-1:0]  head_pc, head_instr, head_ppc;
  logic             head_pv;
  logic [GHR_W-1:0] head_ghr;

  assign wdata = {pc_IF_in, instr_IF_in, predicted_pc_IF_in, prediction_valid_IF_in, ghr_IF_in};
  assign {head_pc, head_instr, head_ppc, head_pv, head_ghr} = rdata;

  // ready comes from registered occupancy only, never from the decode stall
  assign ready_IF_out = ~full;
  assign valid_ID_out = ~empty & ~flush_in;
  assign push         = valid_IF_in & ready_IF_out & ~flush_in;
  assign stall_eff    = stall_ID_in | hazard;
  assign pop          = valid_ID_out & ~stall_eff;

  assign pc_ID_out               = empty ? '0 : head_pc;
  assign instr_ID_out            = empty ? XLEN'(NOP_INSTR) : head_instr;
  assign predicted_pc_ID_out     = empty ? '0 : head_ppc;
  assign prediction_valid_ID_out = empty ? 1'b0 : head_pv;
  assign ghr_ID_out              = empty ? '0 : head_ghr;

`ifdef IFID_LOAD_USE_EN
  // rs2 is compared for every format; a false match only costs one bubble
  assign hazard = valid_ID_out & MemRead_EX_in & (rd_EX_in != 5'd0) &
                  ((rd_EX_in == instr_ID_out[19:15]) | (rd_EX_in == instr_ID_out[24:20]));
`else
  assign hazard = 1'b0;
`endif
  assign bubble_ID_out = hazard;

  pipe_fifo_core #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(flush_in),
    .wdata(wdata),
    .rdata(rdata),
    .count(count_out),
    .full (full),
    .empty(empty)
  );
endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - randomized self-checking bench for if_id_queue against a queue reference model
module tb_if_id_queue;
  import rv_pipe_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 0;
  logic        rst = 1;
  logic        valid_in = 0, ready_out;
  logic [31:0] pc_in = 0, instr_in = 0, ppc_in = 0;
  logic        pv_in = 0;
  logic [3:0]  ghr_in = 0;
  logic        stall_in = 0, flush_in = 0;
  logic        valid_out;
  logic [31:0] pc_out, instr_out, ppc_out;
  logic        pv_out;
  logic [3:0]  ghr_out;
  logic [1:0]  count_out;
  logic        bubble_out;
  logic [4:0]  rd_ex = 0;
  logic        memread_ex = 0;

  int n_checks = 0;
  int n_fail   = 0;
  if_id_entry_t mq[$];
  bit last_acc = 0;
  logic [31:0] next_pc = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .valid_IF_in(valid_in), .ready_IF_out(ready_out),
    .pc_IF_in(pc_in), .instr_IF_in(instr_in), .predicted_pc_IF_in(ppc_in),
    .prediction_valid_IF_in(pv_in), .ghr_IF_in(ghr_in),
    .stall_ID_in(stall_in), .flush_in(flush_in),
    .valid_ID_out(valid_out), .pc_ID_out(pc_out), .instr_ID_out(instr_out),
    .predicted_pc_ID_out(ppc_out), .prediction_valid_ID_out(pv_out),
    .ghr_ID_out(ghr_out), .count_out(count_out), .bubble_ID_out(bubble_out)
`ifdef IFID_LOAD_USE_EN
    , .rd_EX_in(rd_ex), .MemRead_EX_in(memread_ex)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hazard(input bit head_valid);
`ifdef IFID_LOAD_USE_EN
    logic [31:0] ins;
    if (!head_valid) return 0;
    ins = mq[0].instr;
    return memread_ex && rd_ex != 0 && (rd_ex == ins[19:15] || rd_ex == ins[24:20]);
`else
    return head_valid & 1'b0;
`endif
  endfunction

  // compare at negedge, then advance the model by the upcoming posedge
  task automatic tick();
    bit ev, hz, acc;
    if_id_entry_t cur;
    @(negedge clk);
    ev = (mq.size() > 0) && !flush_in;
    hz = model_hazard(ev);
    chk("count", count_out, mq.size());
    chk("ready", ready_out, mq.size() < DEPTH);
    chk("valid", valid_out, ev);
    chk("bubble", bubble_out, hz);
    if (mq.size() > 0) begin
      chk("pc", pc_out, mq[0].pc);
      chk("instr", instr_out, mq[0].instr);
      chk("ppc", ppc_out, mq[0].predicted_pc);
      chk("pv", pv_out, mq[0].prediction_valid);
      chk("ghr", ghr_out, mq[0].ghr);
    end else begin
      chk("pc_empty", pc_out, 0);
      chk("instr_nop", instr_out, 32'h00000013);
      chk("ppc_empty", ppc_out, 0);
      chk("pv_empty", pv_out, 0);
      chk("ghr_empty", ghr_out, 0);
    end
    acc = valid_in && (mq.size() < DEPTH) && !flush_in;
    cur = '{pc: pc_in, instr: instr_in, predicted_pc: ppc_in, prediction_valid: pv_in, ghr: ghr_in};
    if (flush_in) mq.delete();
    else begin
      if (ev && !(stall_in || hz)) void'(mq.pop_front());
      if (acc) mq.push_back(cur);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [3:0] ghr);
    valid_in = 1;
    pc_in    = pc;
    instr_in = $urandom;
    ppc_in   = $urandom;
    pv_in    = 1'($urandom);
    ghr_in   = ghr;
  endtask

  // fetch holds an unaccepted instruction, otherwise offers a new one
  task automatic fetch_next(input bit want);
    if (valid_in && !last_acc) return;
    valid_in = 0;
    if (want) begin
      offer(next_pc, 4'($urandom));
      instr_in[19:15] = 5'($urandom_range(0, 3));
      next_pc += 4;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_instr", instr_out, 32'h00000013);
    rst = 0;
    tick();

    // back-to-back pushes with no stall
    for (int i = 0; i < 3; i++) begin
      offer(32'(4 * i), 4'b1010);
      tick();
    end
    valid_in = 0;
    chk("b2b_count", count_out, 1);
    chk("b2b_ghr", ghr_out, 4'b1010);
    tick();
    tick();

    // stall while pushing three
    stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      offer(32'(4 * i), 4'($urandom));
      tick();
      if (i < 2) chk("stall_acc", last_acc, 1);
    end
    chk("full_ready", ready_out, 0);
    tick();
    stall_in = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (last_acc) valid_in = 0;
    end
    chk("drained", count_out, 0);

    // flush while full with fetch offering
    stall_in = 1;
    for (int i = 0; i < 2; i++) begin
      offer(32'h100 + 32'(4 * i), 4'($urandom));
      tick();
    end
    offer(32'h200, 4'hf);
    flush_in = 1;
    tick();
    flush_in = 0;
    valid_in = 0;
    stall_in = 0;
    chk("flush_count", count_out, 0);
    chk("flush_valid", valid_out, 0);
    tick();

`ifdef IFID_LOAD_USE_EN
    offer(32'h300, 4'h3);
    instr_in = 32'h00208033;
    tick();
    valid_in = 0;
    memread_ex = 1;
    rd_ex = 5'd2;
    tick();
    chk("lu_held", count_out, 1);
    rd_ex = 5'd0;
    tick();
    chk("lu_rd0_pop", count_out, 0);
    memread_ex = 0;
`endif

    // wrap-around with alternating stall
    for (int i = 0; i < 6; i++) begin
      fetch_next(1);
      stall_in = i[0];
      tick();
    end
    stall_in = 0;
    valid_in = 0;
    tick();
    tick();

    // randomized traffic with a mid-stream async reset
    for (int c = 0; c < 2000; c++) begin
      fetch_next($urandom_range(0, 3) != 0);
      stall_in = ($urandom_range(0, 2) == 0);
      flush_in = ($urandom_range(0, 19) == 0);
`ifdef IFID_LOAD_USE_EN
      memread_ex = 1'($urandom);
      rd_ex = 5'($urandom_range(0, 3));
`endif
      if (c == 1000) begin
        #2 rst = 1;
        #1;
        chk("mid_rst_count", count_out, 0);
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_instr", instr_out, 32'h00000013);
        mq.delete();
        valid_in = 0;
        last_acc = 0;
        @(posedge clk);
        #1 rst = 0;
        chk("mid_rst_ready", ready_out, 1);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
